// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared widths, FSM encoding and response record for the Wishbone initiator.
package wb_master_pkg;
    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 64;

    typedef enum logic [1:0] {
        WBM_IDLE,
        WBM_BUS,
        WBM_RESP,
        WBM_GAP
    } wbm_state_e;

    typedef struct packed {
        logic                 err;
        logic                 timeout;
        logic [DAT_WIDTH-1:0] dat;
    } wbm_resp_t;
endpackage

// File: rtl/wb_master_if.sv
// wb_master_if: classic Wishbone bus signals; dat_o/dat_i are named from the master's side.
interface wb_master_if;
    import wb_master_pkg::*;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat_o;
    logic [DAT_WIDTH-1:0] dat_i;
    logic                 we;
    logic                 stb;
    logic                 cyc;
    logic                 ack;
    logic                 err;

    modport master (output adr, dat_o, we, stb, cyc, input dat_i, ack, err);
    modport slave  (input adr, dat_o, we, stb, cyc, output dat_i, ack, err);
endinterface

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone initiator bridging a valid/ready request/response port,
// with a bus-phase timeout so a silent slave cannot stall the requester.
module wb_master
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADR_WIDTH-1:0] req_adr_i,
    input  logic [DAT_WIDTH-1:0] req_dat_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DAT_WIDTH-1:0] resp_dat_o,
    output logic                 resp_err_o,
    output logic                 resp_timeout_o,
    wb_master_if.master          wb
);
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    wbm_state_e           r_state;
    wbm_state_e           w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [DAT_WIDTH-1:0] r_dat;
    logic                 r_we;
    wbm_resp_t            r_resp;
    wbm_resp_t            w_resp;
    logic                 w_accept;
    logic                 w_ack;
    logic                 w_err;
    logic                 w_to;
    logic                 w_done;

    // Reset asserts asynchronously but releases two clocks after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rst_sync <= '0;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= WBM_IDLE;
        else          r_state <= w_next;
    end

    // ack/err only count while stb is high (BUS); err wins over a simultaneous ack.
    always_comb begin
        w_accept = req_valid_i && req_ready_o;
        w_err    = (r_state == WBM_BUS) && wb.err;
        w_ack    = (r_state == WBM_BUS) && wb.ack && !wb.err;
        w_to     = (r_state == WBM_BUS) && !wb.ack && !wb.err && (r_cnt == CNT_WIDTH'(TIMEOUT - 1));
        w_done   = w_ack || w_err || w_to;
        w_resp   = '{err: !w_ack, timeout: w_to, dat: (w_ack && !r_we) ? wb.dat_i : '0};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            WBM_IDLE: w_next = w_accept ? WBM_BUS : WBM_IDLE;
            WBM_BUS:  w_next = w_done ? WBM_RESP : WBM_BUS;
            WBM_RESP: w_next = resp_ready_i ? WBM_GAP : WBM_RESP;
            default:  w_next = WBM_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (r_state == WBM_IDLE) && w_rst_n;
        wb.cyc         = (r_state == WBM_BUS);
        wb.stb         = (r_state == WBM_BUS);
        wb.adr         = r_adr;
        wb.dat_o       = r_dat;
        wb.we          = r_we;
        resp_valid_o   = (r_state == WBM_RESP);
        resp_dat_o     = r_resp.dat;
        resp_err_o     = r_resp.err;
        resp_timeout_o = r_resp.timeout;
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_adr  <= '0;
            r_dat  <= '0;
            r_we   <= 1'b0;
            r_cnt  <= '0;
            r_resp <= '0;
        end else begin
            if (w_accept) begin
                r_adr <= req_adr_i;
                r_dat <= req_dat_i;
                r_we  <= req_we_i;
            end
            r_cnt <= (r_state == WBM_BUS) ? r_cnt + 1'b1 : '0;
            if (w_done)                                     r_resp <= w_resp;
            else if ((r_state == WBM_RESP) && resp_ready_i) r_resp <= '0;
        end
    end
endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: scoreboard bench for wb_master against a 128-word RAM slave model;
// 0x400..0x7FF answers err, 0x800 and above never answers.
module tb_wb_master;
    import wb_master_pkg::*;
    localparam int TO = 8;
    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;

    typedef struct {
        logic [63:0] dat;
        logic        err;
        logic        to;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [63:0] req_dat = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_dat;
    logic        resp_err;
    logic        resp_to;
    logic [63:0] mem [128];
    exp_t        sb[$];
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_rv = 1'b0;
    logic        prev_stb = 1'b0;
    logic        exit_seen = 1'b0;
    bit          phase_seen = 1'b0;
    int          low_run = 0;

    wb_master_if wb();

    wb_master #(.TIMEOUT(TO), .CNT_WIDTH(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_adr_i     (req_adr),
        .req_dat_i     (req_dat),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_dat_o    (resp_dat),
        .resp_err_o    (resp_err),
        .resp_timeout_o(resp_to),
        .wb            (wb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    always @(posedge clk) begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
        if (wb.cyc && wb.stb && !wb.ack && !wb.err) begin
            if (wb.adr < 32'h400) begin
                wb.ack <= 1'b1;
                if (wb.we) mem[wb.adr[9:3]] <= wb.dat_o;
                else       wb.dat_i <= mem[wb.adr[9:3]];
            end else if (wb.adr < 32'h800) begin
                wb.err <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exit_seen) begin
            chk("stb_drop_after_ack_err", {63'd0, wb.stb}, 64'd0);
            chk("rv_after_ack_err", {63'd0, resp_valid}, 64'd1);
        end
        exit_seen = wb.stb && (wb.ack || wb.err);
        if (wb.stb && !prev_stb && phase_seen) chk("stb_gap_ge2", {63'd0, low_run >= 2}, 64'd1);
        if (wb.stb && !prev_stb) phase_seen = 1'b1;
        low_run  = wb.stb ? 0 : low_run + 1;
        prev_stb = wb.stb;
        if (resp_valid && !prev_rv) begin
            chk("cyc_stb_low_on_resp", {62'd0, wb.cyc, wb.stb}, 64'd0);
            if (sb.size() > 0 && sb[0].lat > 0) chk("resp_latency", 64'(cyc_n - sb[0].acc), 64'(sb[0].lat));
        end
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_dat", resp_dat, e.dat);
                chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                chk("resp_timeout", {63'd0, resp_to}, {63'd0, e.to});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [63:0] dat,
                         input logic [63:0] edat, input logic eerr, input logic eto, input int lat);
        int n = 0;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back('{edat, eerr, eto, lat, cyc_n});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() > 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0 || resp_valid) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [63:0] held;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_cyc", {63'd0, wb.cyc}, 64'd0);
        chk("rst_stb", {63'd0, wb.stb}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_resp_timeout", {63'd0, resp_to}, 64'd0);
        chk("rst_resp_dat", resp_dat, 64'd0);
        chk("rst_adr", 64'(wb.adr), 64'd0);
        rst_n = 1'b1;

        issue(1'b1, 32'h10, D1, 64'd0, 1'b0, 1'b0, 3);
        wait_done();
        issue(1'b0, 32'h10, 64'd0, D1, 1'b0, 1'b0, 3);
        wait_done();
        issue(1'b0, 32'h400, 64'd0, 64'd0, 1'b1, 1'b0, 3);
        wait_done();
        issue(1'b0, 32'h800, 64'd0, 64'd0, 1'b1, 1'b1, TO + 1);
        wait_done();

        issue(1'b1, 32'h18, D2, 64'd0, 1'b0, 1'b0, 3);
        issue(1'b0, 32'h18, 64'd0, D2, 1'b0, 1'b0, 3);
        issue(1'b0, 32'h10, 64'd0, D1, 1'b0, 1'b0, 3);
        wait_done();

        resp_ready = 1'b0;
        issue(1'b0, 32'h18, 64'd0, D2, 1'b0, 1'b0, 3);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h10;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_arrived", {63'd0, resp_valid}, 64'd1);
        held = resp_dat;
        chk("bp_first_dat", held, D2);
        repeat (5) begin
            @(negedge clk);
            chk("bp_dat_stable", resp_dat, D2);
            chk("bp_valid_held", {63'd0, resp_valid}, 64'd1);
            chk("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
            chk("bp_no_stb", {63'd0, wb.stb}, 64'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        issue(1'b0, 32'h10, 64'd0, D1, 1'b0, 1'b0, 3);
        wait_done();

        issue(1'b0, 32'h800, 64'd0, 64'd0, 1'b1, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_stb", {63'd0, wb.stb}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {63'd0, wb.cyc}, 64'd0);
        chk("midrst_stb", {63'd0, wb.stb}, 64'd0);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 32'h18, 64'd0, D2, 1'b0, 1'b0, 3);
        wait_done();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
